uvmt_obi_st_arbiter: RTL

- N-to-1 OBI arbiter for the OBI self-test environment; shares one OBI slave port between NUM_MSTR master ports.
- Round-robin address-phase arbitration, holding the selection stable while the slave stalls, per the OBI rule that req and address stay stable until gnt.
- In-order response routing through an ID FIFO of outstanding transactions.
- Sits between multiple uvma_obi_if master agents and a single slave agent/DUT in the self-test wrapper.

---
 rtl/uvmt_obi_st_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uvmt_obi_st_arbiter.sv
// N-to-1 OBI arbiter: round-robin address-phase selection with stall lock and in-order response routing.
// Define UVMT_OBI_ST_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module uvmt_obi_st_arbiter #(
  parameter int unsigned NUM_MSTR        = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_MSTR-1:0]                  mstr_req_i,
  output logic [NUM_MSTR-1:0]                  mstr_gnt_o,
  input  logic [NUM_MSTR*ADDR_WIDTH-1:0]       mstr_addr_i,
  input  logic [NUM_MSTR-1:0]                  mstr_we_i,
  input  logic [NUM_MSTR*DATA_WIDTH/8-1:0]     mstr_be_i,
  input  logic [NUM_MSTR*DATA_WIDTH-1:0]       mstr_wdata_i,
  output logic [NUM_MSTR-1:0]                  mstr_rvalid_o,
  input  logic [NUM_MSTR-1:0]                  mstr_rready_i,
  output logic [DATA_WIDTH-1:0]                mstr_rdata_o,
  output logic                                 slv_req_o,
  input  logic                                 slv_gnt_i,
  output logic [ADDR_WIDTH-1:0]                slv_addr_o,
  output logic                                 slv_we_o,
  output logic [DATA_WIDTH/8-1:0]              slv_be_o,
  output logic [DATA_WIDTH-1:0]                slv_wdata_o,
  input  logic                                 slv_rvalid_i,
  output logic                                 slv_rready_o,
  input  logic [DATA_WIDTH-1:0]                slv_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
  output logic                                 unexp_rsp_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W    = (NUM_MSTR > 1) ? $clog2(NUM_MSTR) : 1;
  localparam int unsigned PTR_W    = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W    = PTR_W + 1;

  typedef logic [IDX_W-1:0] idx_t;

  idx_t             sel;
  idx_t             sel_free;
  idx_t             lock_idx;
  idx_t             head;
  logic             lock;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             unexp_q;
  logic             full;
  logic             empty;
  logic             accept;
  logic             stall;
  logic             pop;
  idx_t             fifo_mem [MAX_OUTSTANDING];

`ifdef UVMT_OBI_ST_ARB_FIXED_PRIO_EN
  // Scan downwards so the lowest requesting index is the last one written.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sel_free = '0;
    for (int i = int'(NUM_MSTR) - 1; i >= 0; i--) begin
      if (mstr_req_i[i]) sel_free = idx_t'(i);
    end
  end
`else
  idx_t rr_ptr;

  always_comb begin
    logic found;
    int   cand;
    sel_free = rr_ptr;
    found    = 1'b0;
    cand     = 0;
    for (int i = 0; i < int'(NUM_MSTR); i++) begin
      cand = (int'(rr_ptr) + i) % int'(NUM_MSTR);
      if (!found && mstr_req_i[cand]) begin
        sel_free = idx_t'(cand);
        found    = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    rr_ptr <= '0;
    else if (accept) rr_ptr <= idx_t'((int'(sel) + 1) % int'(NUM_MSTR));
  end
`endif

  // A stalled request keeps its master selected until the slave grants it.
  assign sel    = lock ? lock_idx : sel_free;
  assign full   = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty  = (count == '0);

  assign slv_req_o   = mstr_req_i[sel] && !full;
  assign slv_addr_o  = mstr_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign slv_we_o    = mstr_we_i[sel];
  assign slv_be_o    = mstr_be_i[sel*BE_WIDTH +: BE_WIDTH];
  assign slv_wdata_o = mstr_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];

  assign accept     = slv_req_o && slv_gnt_i;
  assign stall      = slv_req_o && !slv_gnt_i;
  assign mstr_gnt_o = accept ? (NUM_MSTR'(1) << sel) : '0;

  // Responses return in acceptance order; the FIFO head names their owner.
  assign head          = fifo_mem[rd_ptr];
  assign slv_rready_o  = empty ? 1'b1 : mstr_rready_i[head];
  assign mstr_rvalid_o = (slv_rvalid_i && !empty) ? (NUM_MSTR'(1) << head) : '0;
  assign mstr_rdata_o  = slv_rdata_i;
  assign pop           = slv_rvalid_i && slv_rready_o && !empty;

  assign outstanding_o = count;
  assign unexp_rsp_o   = unexp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock     <= 1'b0;
      lock_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      unexp_q  <= 1'b0;
    end else begin
      if (accept) begin
        lock <= 1'b0;
      end else if (stall) begin
        lock     <= 1'b1;
        lock_idx <= sel;
      end
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (slv_rvalid_i && empty) unexp_q <= 1'b1;
    end
  end

  // NOTE: the ID storage has no reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= sel;
  end

endmodule
